// File: rtl/mem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_arb_pkg
// Brief   : Shared IDs, FSM state and access-size encodings for mem_req_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

`default_nettype wire

// File: rtl/arb_id_fifo.sv
//------------------------------------------------------------------------------
// Module  : arb_id_fifo
// Brief   : 1-bit-wide FIFO holding requester IDs of outstanding transactions.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PTR_W + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_req_arbiter
// Brief   : Shares one memory port between inst fetch and data access; routes
//           in-order responses. Optional starvation guard: ARB_STARVE_GUARD_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       w_sel;
  logic       w_sel_req;
  logic       w_mem_req;
  logic       w_accept;
  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_pop;
  logic       w_prefer_inst;

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] r_starve_cnt;

  // Saturates at the limit; inst acceptance or a dropped request clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!inst_req || inst_addr_ok) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt < STARVE_W'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_prefer_inst = inst_req & (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));
`else
  assign w_prefer_inst = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A stalled request locks the grant so the requester's fields stay on the bus.
  always_comb begin
    w_sel       = ID_INST;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_prefer_inst)  w_sel = ID_INST;
        else if (data_req)  w_sel = ID_DATA;
        else                w_sel = ID_INST;
      end
      LOCK_INST: w_sel = ID_INST;
      LOCK_DATA: w_sel = ID_DATA;
      default:   w_sel = ID_INST;
    endcase

    w_sel_req = (w_sel == ID_DATA) ? data_req : inst_req;
    w_mem_req = w_sel_req & ~w_full & ~rst;

    case (r_state)
      IDLE: begin
        if (w_mem_req && !mem_addr_ok) begin
          w_state_nxt = (w_sel == ID_DATA) ? LOCK_DATA : LOCK_INST;
        end
      end
      LOCK_INST, LOCK_DATA: begin
        if (w_mem_req && mem_addr_ok) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = w_mem_req & mem_addr_ok;
  assign w_pop    = mem_data_ok & ~w_empty;

  assign mem_req   = w_mem_req;
  assign mem_wr    = (w_sel == ID_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (w_sel == ID_DATA) ? data_size  : inst_size;
  assign mem_wstrb = (w_sel == ID_DATA) ? data_wstrb : inst_wstrb;
  assign mem_addr  = (w_sel == ID_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (w_sel == ID_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = w_accept & (w_sel == ID_INST);
  assign data_addr_ok = w_accept & (w_sel == ID_DATA);

  assign inst_data_ok = w_pop & (w_head == ID_INST);
  assign data_data_ok = w_pop & (w_head == ID_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  arb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_accept),
    .din   (w_sel),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_req_arbiter
// Brief   : Directed self-checking bench with an ID scoreboard for responses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int   total = 0;
  int   bad   = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .MAX_OUTST    (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Drives one downstream response and checks it lands on the scoreboard's owner.
  task automatic rsp(input string tag, input logic [31:0] rd);
    logic id;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    settle();
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=response expected=empty_scoreboard", tag);
    end else begin
      id = exp_q.pop_front();
      chk({tag, "/inst_data_ok"}, inst_data_ok, id == ID_INST);
      chk({tag, "/data_data_ok"}, data_data_ok, id == ID_DATA);
      chk({tag, "/rdata"}, (id == ID_INST) ? inst_rdata : data_rdata, rd);
    end
  endtask

  initial begin
    int first;
    int exp_first;

    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'h0;
    inst_addr = 0; inst_wdata = 0;
    data_req = 1; data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'h0;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 1; mem_data_ok = 0; mem_rdata = 0;

    // Reset state: even with a pending request nothing is issued.
    #12;
    chk("rst/mem_req", mem_req, 0);
    chk("rst/data_addr_ok", data_addr_ok, 0);
    chk("rst/inst_addr_ok", inst_addr_ok, 0);
    chk("rst/data_ok", {inst_data_ok, data_data_ok}, 0);
    #1;
    rst = 1'b0;
    data_req = 0;
    mem_addr_ok = 0;
    tick();

    // Single load.
    data_req = 1; data_addr = 32'h1000; mem_addr_ok = 1;
    settle();
    chk("load/mem_req", mem_req, 1);
    chk("load/mem_addr", mem_addr, 32'h1000);
    chk("load/data_addr_ok", data_addr_ok, 1);
    chk("load/inst_addr_ok", inst_addr_ok, 0);
    if (data_addr_ok) exp_q.push_back(ID_DATA);
    tick();
    data_req = 0; mem_addr_ok = 0;
    rsp("load_rsp", 32'hDEADBEEF);
    tick();
    mem_data_ok = 0;

    // Contention: data first, then inst; fields follow the grant.
    inst_req = 1; inst_addr = 32'h2000; inst_wr = 0; inst_size = SZ_HALF;
    inst_wstrb = 4'h3; inst_wdata = 32'h1111;
    data_req = 1; data_addr = 32'h3000; data_wr = 1; data_size = SZ_WORD;
    data_wstrb = 4'hF; data_wdata = 32'h55AA;
    mem_addr_ok = 1;
    settle();
    chk("cont1/data_addr_ok", data_addr_ok, 1);
    chk("cont1/inst_addr_ok", inst_addr_ok, 0);
    chk("cont1/mem_addr", mem_addr, 32'h3000);
    chk("cont1/mem_wr", mem_wr, 1);
    chk("cont1/mem_wdata", mem_wdata, 32'h55AA);
    chk("cont1/mem_wstrb", mem_wstrb, 4'hF);
    if (data_addr_ok) exp_q.push_back(ID_DATA);
    tick();
    data_req = 0;
    settle();
    chk("cont2/inst_addr_ok", inst_addr_ok, 1);
    chk("cont2/mem_addr", mem_addr, 32'h2000);
    chk("cont2/mem_size", mem_size, SZ_HALF);
    chk("cont2/mem_wr", mem_wr, 0);
    if (inst_addr_ok) exp_q.push_back(ID_INST);
    tick();
    inst_req = 0; mem_addr_ok = 0; data_wr = 0;
    rsp("cont_rsp1", 32'hA5A5_0001);
    tick();
    rsp("cont_rsp2", 32'hA5A5_0002);
    tick();
    mem_data_ok = 0;

    // Grant lock: inst stalled, data arrives, inst keeps the bus until accepted.
    inst_req = 1; inst_addr = 32'h4000; data_addr = 32'h5000;
    settle();
    chk("lock1/mem_req", mem_req, 1);
    chk("lock1/mem_addr", mem_addr, 32'h4000);
    chk("lock1/inst_addr_ok", inst_addr_ok, 0);
    tick();
    data_req = 1;
    settle();
    chk("lock2/mem_addr", mem_addr, 32'h4000);
    chk("lock2/data_addr_ok", data_addr_ok, 0);
    tick();
    settle();
    chk("lock3/mem_addr", mem_addr, 32'h4000);
    tick();
    mem_addr_ok = 1;
    settle();
    chk("lock4/inst_addr_ok", inst_addr_ok, 1);
    chk("lock4/data_addr_ok", data_addr_ok, 0);
    chk("lock4/mem_addr", mem_addr, 32'h4000);
    if (inst_addr_ok) exp_q.push_back(ID_INST);
    tick();
    inst_req = 0;
    settle();
    chk("lock5/data_addr_ok", data_addr_ok, 1);
    chk("lock5/mem_addr", mem_addr, 32'h5000);
    if (data_addr_ok) exp_q.push_back(ID_DATA);
    tick();
    data_req = 0; mem_addr_ok = 0;
    rsp("lock_rsp1", 32'h0000_4444);
    tick();
    rsp("lock_rsp2", 32'h0000_5555);
    tick();
    mem_data_ok = 0;

    // Full stall: four inst reads fill the ID FIFO.
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      inst_addr = 32'h100 + 32'(4 * i);
      settle();
      chk($sformatf("fill%0d/inst_addr_ok", i), inst_addr_ok, 1);
      if (inst_addr_ok) exp_q.push_back(ID_INST);
      tick();
    end
    inst_addr = 32'h110;
    settle();
    chk("full/mem_req", mem_req, 0);
    chk("full/inst_addr_ok", inst_addr_ok, 0);
    tick();
    rsp("full_pop", 32'h0000_00A1);
    chk("full_pop/mem_req", mem_req, 0);
    tick();
    mem_data_ok = 0;
    settle();
    chk("resume/mem_req", mem_req, 1);
    chk("resume/inst_addr_ok", inst_addr_ok, 1);
    if (inst_addr_ok) exp_q.push_back(ID_INST);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    for (int i = 0; i < 4; i++) begin
      rsp($sformatf("drain%0d", i), 32'hA2 + 32'(i));
      tick();
    end
    mem_data_ok = 0;

    // Ordering: inst, data, inst issued back to back.
    mem_addr_ok = 1;
    inst_req = 1; inst_addr = 32'h600;
    settle();
    chk("ord1/inst_addr_ok", inst_addr_ok, 1);
    if (inst_addr_ok) exp_q.push_back(ID_INST);
    tick();
    inst_req = 0; data_req = 1; data_addr = 32'h700;
    settle();
    chk("ord2/data_addr_ok", data_addr_ok, 1);
    if (data_addr_ok) exp_q.push_back(ID_DATA);
    tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h604;
    settle();
    chk("ord3/inst_addr_ok", inst_addr_ok, 1);
    if (inst_addr_ok) exp_q.push_back(ID_INST);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    rsp("ord_rsp1", 32'h1);
    tick();
    rsp("ord_rsp2", 32'h2);
    tick();
    rsp("ord_rsp3", 32'h3);
    tick();
    mem_rdata = 32'h4;
    settle();
    chk("stray/inst_data_ok", inst_data_ok, 0);
    chk("stray/data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 0;

    // Async reset with two outstanding transactions.
    mem_addr_ok = 1;
    inst_req = 1;
    settle();
    chk("pre_rst1/inst_addr_ok", inst_addr_ok, 1);
    if (inst_addr_ok) exp_q.push_back(ID_INST);
    tick();
    inst_req = 0; data_req = 1;
    settle();
    chk("pre_rst2/data_addr_ok", data_addr_ok, 1);
    if (data_addr_ok) exp_q.push_back(ID_DATA);
    tick();
    data_req = 0; inst_req = 1; mem_data_ok = 1; mem_rdata = 32'h77;
    #2;
    rst = 1'b1;
    #1;
    chk("arst/mem_req", mem_req, 0);
    chk("arst/inst_addr_ok", inst_addr_ok, 0);
    chk("arst/inst_data_ok", inst_data_ok, 0);
    chk("arst/data_data_ok", data_data_ok, 0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    inst_req = 0;
    #1;
    chk("post_rst/inst_data_ok", inst_data_ok, 0);
    chk("post_rst/data_data_ok", data_data_ok, 0);
    tick();
    mem_data_ok = 0;
    data_req = 1; data_addr = 32'h800;
    settle();
    chk("post_rst/data_addr_ok", data_addr_ok, 1);
    if (data_addr_ok) exp_q.push_back(ID_DATA);
    tick();
    data_req = 0; mem_addr_ok = 0;
    rsp("post_rst_rsp", 32'h0000_0888);
    tick();
    mem_data_ok = 0;

    // Starvation: data requests back to back, inst waiting; responses keep
    // the FIFO from filling.
`ifdef ARB_STARVE_GUARD_EN
    exp_first = 8;
`else
    exp_first = -1;
`endif
    first = -1;
    data_req = 1; inst_req = 1; inst_addr = 32'h900;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 0;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (inst_addr_ok && first < 0) first = k;
      tick();
      if (first >= 0) inst_req = 0;
    end
    chk("starve/first_inst_accept", first, exp_first);
    data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
